// File: rtl/rlwe_seq_pkg.sv
// Shared constants for the RLWE command sequencer: command layout, opcodes,
// error codes and FSM states.
package rlwe_seq_pkg;

  localparam int unsigned CMD_W  = 10;
  localparam int unsigned WD_W   = 15;
  localparam int unsigned FIELD_W = 2;

  // Command word bit positions
  localparam int unsigned OPC_MSB     = 9;
  localparam int unsigned OPC_LSB     = 7;
  localparam int unsigned INSTR_MSB   = 6;
  localparam int unsigned INSTR_LSB   = 5;
  localparam int unsigned ITER_MSB    = 4;
  localparam int unsigned ITER_LSB    = 3;
  localparam int unsigned MOD_BIT     = 2;
  localparam int unsigned ADDCONV_BIT = 1;
  localparam int unsigned RSVD_BIT    = 0;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_ARITH = 3'd2;
  localparam logic [2:0] OP_NTT   = 3'd3;
  localparam logic [2:0] OP_CRT   = 3'd4;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_RUN       = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_DONE      = 3'd4,
    S_ERR       = 3'd5
  } state_e;

endpackage

// File: rtl/rlwe_seq_watchdog.sv
// 15-bit up-counter with synchronous clear; flags when the count reaches limit
// while enabled. Serves both the settle delay and the done watchdog.
module rlwe_seq_watchdog
  import rlwe_seq_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  input  logic [WD_W-1:0] limit,
  output logic            expired_c
);

  logic [WD_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + WD_W'(1);
    end
  end

  assign expired_c = en && (count == limit);

endmodule

// File: rtl/rlwe_cmd_sequencer.sv
// Command sequencer for the seven-lane RLWE processor: accepts packed commands,
// drives one unit strobe low per command, waits for done and reports status.
module rlwe_cmd_sequencer
  import rlwe_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16384,
  parameter int unsigned SETTLE_CYCLES  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  input  logic [CMD_W-1:0]   cmd_data,
  output logic               cmd_ready,
  input  logic               err_clr,
  input  logic               done,
  output logic               rst_ld,
  output logic               rst_ac,
  output logic               rst_nc,
  output logic               rst_crt,
  output logic [FIELD_W-1:0] INSTRUCTION_ld,
  output logic [FIELD_W-1:0] INSTRUCTION_nc,
  output logic [FIELD_W-1:0] NTT_ITERATION,
  output logic               modulus_sel,
  output logic               add_conv,
  output logic               busy,
  output logic               op_done,
  output logic               op_error,
  output logic [1:0]         err_code
);

  localparam logic [WD_W-1:0] TIMEOUT_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0] SETTLE_LIMIT  = WD_W'(SETTLE_CYCLES - 1);

  state_e     state;
  logic [2:0] op_q;

  logic [2:0]         opc_c;
  logic               wd_en_c;
  logic               wd_clr_c;
  logic               wd_expired_c;
  logic [WD_W-1:0]    wd_limit_c;
  logic               rsvd_unused_c;

  assign opc_c         = cmd_data[OPC_MSB:OPC_LSB];
  assign rsvd_unused_c = cmd_data[RSVD_BIT];

  // Counter runs through RUN then WAIT_DONE, restarting at the hand-over
  assign wd_en_c    = (state == S_RUN) || (state == S_WAIT_DONE);
  assign wd_clr_c   = !wd_en_c || ((state == S_RUN) && wd_expired_c);
  assign wd_limit_c = (state == S_RUN) ? SETTLE_LIMIT : TIMEOUT_LIMIT;

  rlwe_seq_watchdog u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .clr       (wd_clr_c),
    .en        (wd_en_c),
    .limit     (wd_limit_c),
    .expired_c (wd_expired_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      op_q           <= OP_NOP;
      rst_ld         <= 1'b1;
      rst_ac         <= 1'b1;
      rst_nc         <= 1'b1;
      rst_crt        <= 1'b1;
      INSTRUCTION_ld <= '0;
      INSTRUCTION_nc <= '0;
      NTT_ITERATION  <= '0;
      modulus_sel    <= 1'b0;
      add_conv       <= 1'b0;
      cmd_ready      <= 1'b1;
      busy           <= 1'b0;
      op_done        <= 1'b0;
      op_error       <= 1'b0;
      err_code       <= ERR_NONE;
    end else begin
      op_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            op_q      <= opc_c;
            if (opc_c == OP_NOP) begin
              state   <= S_DONE;
              busy    <= 1'b1;
              op_done <= 1'b1;
            end else if (opc_c > OP_CRT) begin
              state    <= S_ERR;
              op_error <= 1'b1;
              err_code <= ERR_ILLEGAL;
            end else begin
              state       <= S_ISSUE;
              busy        <= 1'b1;
              modulus_sel <= cmd_data[MOD_BIT];
              // Only the fields owned by this opcode are updated
              case (opc_c)
                OP_LOAD:  INSTRUCTION_ld <= cmd_data[INSTR_MSB:INSTR_LSB];
                OP_ARITH: add_conv       <= cmd_data[ADDCONV_BIT];
                OP_NTT: begin
                  INSTRUCTION_nc <= cmd_data[INSTR_MSB:INSTR_LSB];
                  NTT_ITERATION  <= cmd_data[ITER_MSB:ITER_LSB];
                end
                default: ;
              endcase
            end
          end
        end
        S_ISSUE: begin
          state <= S_RUN;
          case (op_q)
            OP_LOAD:  rst_ld  <= 1'b0;
            OP_ARITH: rst_ac  <= 1'b0;
            OP_NTT:   rst_nc  <= 1'b0;
            OP_CRT:   rst_crt <= 1'b0;
            default: ;
          endcase
        end
        S_RUN: begin
          if (wd_expired_c) begin
            state <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          // done takes priority over a same-cycle timeout
          if (done) begin
            state   <= S_DONE;
            op_done <= 1'b1;
            rst_ld  <= 1'b1;
            rst_ac  <= 1'b1;
            rst_nc  <= 1'b1;
            rst_crt <= 1'b1;
          end else if (wd_expired_c) begin
            state    <= S_ERR;
            busy     <= 1'b0;
            op_error <= 1'b1;
            err_code <= ERR_TIMEOUT;
            rst_ld   <= 1'b1;
            rst_ac   <= 1'b1;
            rst_nc   <= 1'b1;
            rst_crt  <= 1'b1;
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
        S_ERR: begin
          if (err_clr) begin
            state     <= S_IDLE;
            op_error  <= 1'b0;
            err_code  <= ERR_NONE;
            cmd_ready <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          rst_ld    <= 1'b1;
          rst_ac    <= 1'b1;
          rst_nc    <= 1'b1;
          rst_crt   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rlwe_cmd_sequencer.sv
// Directed bench for rlwe_cmd_sequencer: a per-cycle vector table for the
// command flows plus hand sequences for mid-op reset and back-to-back NOPs.
module tb_rlwe_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic [9:0] cmd_data;
  logic       cmd_ready;
  logic       err_clr;
  logic       done;
  logic       rst_ld, rst_ac, rst_nc, rst_crt;
  logic [1:0] INSTRUCTION_ld, INSTRUCTION_nc, NTT_ITERATION;
  logic       modulus_sel, add_conv;
  logic       busy, op_done, op_error;
  logic [1:0] err_code;

  int n_tests = 0;
  int n_fail  = 0;

  rlwe_cmd_sequencer #(.TIMEOUT_CYCLES(16), .SETTLE_CYCLES(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_data       (cmd_data),
    .cmd_ready      (cmd_ready),
    .err_clr        (err_clr),
    .done           (done),
    .rst_ld         (rst_ld),
    .rst_ac         (rst_ac),
    .rst_nc         (rst_nc),
    .rst_crt        (rst_crt),
    .INSTRUCTION_ld (INSTRUCTION_ld),
    .INSTRUCTION_nc (INSTRUCTION_nc),
    .NTT_ITERATION  (NTT_ITERATION),
    .modulus_sel    (modulus_sel),
    .add_conv       (add_conv),
    .busy           (busy),
    .op_done        (op_done),
    .op_error       (op_error),
    .err_code       (err_code)
  );

  always #5 clk = ~clk;

  // {strobes ld/ac/nc/crt, ready, busy, op_done, op_error, err_code, fields}
  logic [17:0] obs;
  assign obs = {rst_ld, rst_ac, rst_nc, rst_crt, cmd_ready, busy, op_done, op_error,
                err_code, INSTRUCTION_ld, INSTRUCTION_nc, NTT_ITERATION, modulus_sel, add_conv};

  typedef struct {
    logic        valid;
    logic [9:0]  data;
    logic        dn;
    logic        clr;
    logic [17:0] exp;
    string       tag;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [9:0] mkcmd(input logic [2:0] op, input logic [1:0] ins,
                                       input logic [1:0] it, input logic ms, input logic ac);
    return {op, ins, it, ms, ac, 1'b0};
  endfunction

  function automatic logic [7:0] fld(input logic [1:0] ild, input logic [1:0] inc,
                                     input logic [1:0] it, input logic ms, input logic ac);
    return {ild, inc, it, ms, ac};
  endfunction

  task automatic add(input logic v, input logic [9:0] d, input logic dn, input logic c,
                     input logic [3:0] s, input logic rdy, input logic bsy, input logic opd,
                     input logic oer, input logic [1:0] ec, input logic [7:0] f, input string tag);
    vec_t r;
    r.valid = v; r.data = d; r.dn = dn; r.clr = c;
    r.exp = {s, rdy, bsy, opd, oer, ec, f};
    r.tag = tag;
    vecs.push_back(r);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  localparam logic [3:0] S_ALL = 4'b1111;

  initial begin
    logic [7:0] f0, f1, f2, f3;
    logic [9:0] c_ntt, c_ld, c_ld2, c_ill, c_ar, c_crt, c_ld3;
    int acc, last, gap_bad, opd_cnt, moved;

    rst = 1'b1; cmd_valid = 1'b0; cmd_data = '0; err_clr = 1'b0; done = 1'b0;

    c_ntt = mkcmd(3'd3, 2'd2, 2'd1, 1'b1, 1'b0);
    c_ld  = mkcmd(3'd1, 2'd3, 2'd0, 1'b0, 1'b0);
    c_ld2 = mkcmd(3'd1, 2'd1, 2'd0, 1'b1, 1'b0);
    c_ill = mkcmd(3'd6, 2'd0, 2'd0, 1'b0, 1'b0);
    c_ar  = mkcmd(3'd2, 2'd1, 2'd3, 1'b1, 1'b1);
    c_crt = mkcmd(3'd4, 2'd0, 2'd0, 1'b0, 1'b0);
    c_ld3 = mkcmd(3'd1, 2'd2, 2'd0, 1'b1, 1'b0);
    f0 = fld(2'd0, 2'd2, 2'd1, 1'b1, 1'b0);
    f1 = fld(2'd3, 2'd2, 2'd1, 1'b0, 1'b0);
    f2 = fld(2'd3, 2'd2, 2'd1, 1'b1, 1'b1);
    f3 = fld(2'd3, 2'd2, 2'd1, 1'b0, 1'b1);

    // NTT: fields at t+1, rst_nc low t+2..t+10, done at t+10, op_done t+11
    add(1'b1, c_ntt, 1'b0, 1'b0, S_ALL, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, f0, "ntt");
    for (int i = 1; i <= 9; i++)
      add(1'b0, '0, 1'b0, 1'b0, 4'b1101, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, f0, "ntt");
    add(1'b0, '0, 1'b1, 1'b0, S_ALL, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, f0, "ntt");
    add(1'b0, '0, 1'b0, 1'b0, S_ALL, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, f0, "ntt");

    // LOAD with stale done through t+2; real done at t+8
    add(1'b1, c_ld, 1'b1, 1'b0, S_ALL, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, f1, "ld_stale");
    add(1'b0, '0, 1'b1, 1'b0, 4'b0111, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, f1, "ld_stale");
    add(1'b0, '0, 1'b1, 1'b0, 4'b0111, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, f1, "ld_stale");
    for (int i = 3; i <= 7; i++)
      add(1'b0, '0, 1'b0, 1'b0, 4'b0111, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, f1, "ld_stale");
    add(1'b0, '0, 1'b1, 1'b0, S_ALL, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, f1, "ld_stale");
    add(1'b0, '0, 1'b0, 1'b0, S_ALL, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, f1, "ld_stale");

    // Illegal opcode 6: sticky error, commands refused until err_clr
    add(1'b1, c_ill, 1'b0, 1'b0, S_ALL, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, f1, "illegal");
    add(1'b0, '0, 1'b0, 1'b0, S_ALL, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, f1, "illegal");
    add(1'b1, c_ld2, 1'b0, 1'b0, S_ALL, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, f1, "illegal");
    add(1'b0, '0, 1'b0, 1'b1, S_ALL, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, f1, "illegal");
    add(1'b0, '0, 1'b0, 1'b1, S_ALL, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, f1, "clr_idle");

    // ARITH timeout: WAIT_DONE t+4..t+19, error at t+20; err_clr mid-op ignored
    add(1'b1, c_ar, 1'b0, 1'b0, S_ALL, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, f2, "timeout");
    for (int i = 1; i <= 18; i++)
      add(1'b0, '0, 1'b0, (i == 10), 4'b1011, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, f2, "timeout");
    add(1'b0, '0, 1'b0, 1'b0, S_ALL, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, f2, "timeout");
    add(1'b0, '0, 1'b0, 1'b1, S_ALL, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, f2, "timeout");

    repeat (3) @(posedge clk);
    #1;
    check("reset_vals", 32'(obs), 32'({S_ALL, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00}));
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_after_reset", 32'(obs), 32'({S_ALL, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00}));

    foreach (vecs[i]) begin
      cmd_valid = vecs[i].valid;
      cmd_data  = vecs[i].data;
      done      = vecs[i].dn;
      err_clr   = vecs[i].clr;
      @(posedge clk); #1;
      n_tests++;
      if (obs !== vecs[i].exp) begin
        n_fail++;
        $display("FAIL %s[%0d]: got %05h expected %05h", vecs[i].tag, i, obs, vecs[i].exp);
      end
    end
    cmd_valid = 1'b0; done = 1'b0; err_clr = 1'b0;

    // Reset while CRT waits for done
    cmd_valid = 1'b1; cmd_data = c_crt;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("crt_wait", 32'(obs), 32'({4'b1110, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, f3}));
    #2 rst = 1'b1;
    #1;
    check("crt_async_reset", 32'(obs), 32'({S_ALL, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00}));
    rst = 1'b0;
    cmd_valid = 1'b1; cmd_data = c_ld3;
    @(posedge clk); #1;
    check("load_after_reset", 32'(obs),
          32'({S_ALL, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, fld(2'd2, 2'd0, 2'd0, 1'b1, 1'b0)}));
    cmd_valid = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk); #1;

    // Five back-to-back NOPs with junk fields that must not be latched
    acc = 0; last = -1; gap_bad = 0; opd_cnt = 0; moved = 0;
    cmd_data = mkcmd(3'd0, 2'd3, 2'd3, 1'b1, 1'b1);
    for (int c = 0; c < 14; c++) begin
      cmd_valid = (acc < 5);
      if (cmd_valid && cmd_ready) begin
        if (last >= 0 && (c - last) != 2) gap_bad++;
        last = c;
        acc++;
      end
      @(posedge clk); #1;
      if (op_done) opd_cnt++;
      if ({rst_ld, rst_ac, rst_nc, rst_crt} !== S_ALL) moved++;
    end
    cmd_valid = 1'b0;
    check("nop_accepts", 32'(acc), 32'd5);
    check("nop_op_done_pulses", 32'(opd_cnt), 32'd5);
    check("nop_accept_gap", 32'(gap_bad), 32'd0);
    check("nop_strobe_moves", 32'(moved), 32'd0);
    check("nop_final", 32'(obs), 32'({S_ALL, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00}));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
